seq_div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops in the EX stage.
//  It is the subtract/shift counterpart to the adder datapath and resolves one quotient bit per cycle.
//  It stalls the pipeline through a start/ready/done handshake and tags each result with its rd for writeback.

---
 rtl/rv32m_pkg.sv | 33 +++
 rtl/div_step.sv | 37 +++
 rtl/seq_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_seq_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared types, constants and helpers for the RV32M sequential divider
//
// Purpose: operation and state encodings plus small decode helpers used by
// seq_div_unit. The operation encoding matches funct3[1:0] of DIV/DIVU/REM/REMU.
package rv32m_pkg;

  localparam int XLEN_C    = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } div_state_e;

  // funct3[0] clear means the signed flavour (DIV, REM).
  function automatic logic is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  // funct3[1] set selects the remainder (REM, REMU).
  function automatic logic want_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring-division iteration
//
// Purpose: shifts {rem,quo} left by one, trial-subtracts the divisor from the
// widened partial remainder and keeps the difference when it is non-negative.
// Ports:
//   rem_in   partial remainder before the step
//   quo_in   quotient/dividend shift register before the step
//   divisor  divisor magnitude
//   rem_out  partial remainder after the step
//   quo_out  quotient/dividend shift register after the step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0]   rem_sh;
  logic [W-1:0] diff;
  logic         fits;

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  assign rem_sh = {rem_in, quo_in[W-1]};
  assign fits   = (rem_sh >= {1'b0, divisor});
  // When the divisor fits, the true difference is below the divisor, so the
  // low W bits of the subtraction are exact.
  assign diff   = rem_sh[W-1:0] - divisor;

  always_comb begin
    rem_out = fits ? diff : rem_sh[W-1:0];
    quo_out = {quo_in[W-2:0], fits};
  end

endmodule

// File: rtl/seq_div_unit.sv
// rtl/seq_div_unit.sv - multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose: accepts one op when start && ready, iterates one quotient bit per
// clock, applies sign fixup and strobes done for one cycle with the tagged result.
// Optional macro DIV_SPECIAL_FASTPATH_EN: divide-by-zero and signed overflow
// skip the iteration and complete one clock after the start cycle.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, flush     op request, pipeline flush (abandons in-flight op)
//   op, rs1, rs2     operation (funct3[1:0]), dividend, divisor
//   tag_in           rd of the request
//   ready            high while IDLE
//   done             one-cycle completion strobe
//   result, tag_out  quotient or remainder and its tag, valid with done
module seq_div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ready,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(DIV_STEPS);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  div_op_e          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  div_op_e         op_in;
  logic            sgn_in;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign op_in   = div_op_e'(op);
  assign sgn_in  = is_signed(op_in);
  assign rs1_abs = (sgn_in && rs1[XLEN-1]) ? -rs1 : rs1;
  assign rs2_abs = (sgn_in && rs2[XLEN-1]) ? -rs2 : rs2;

  div_step #(.W(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // A zero divisor leaves quo all ones and rem = |rs1|; suppressing the
  // quotient negation and negating rem by sa restores rs1 itself.
  assign quo_fix = (is_signed(op_q) && (sa_q != sb_q) && !dz_q) ? -quo_q : quo_q;
  assign rem_fix = (is_signed(op_q) && sa_q) ? -rem_q : rem_q;

`ifdef DIV_SPECIAL_FASTPATH_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic ovf_in;
  assign ovf_in = sgn_in && (rs1 == MIN_NEG) && (rs2 == '1);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    op_d      = op_q;
    tag_d     = tag_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    result_d  = result_q;
    tag_out_d = tag_out_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = op_in;
          tag_d   = tag_in;
          sa_d    = rs1[XLEN-1];
          sb_d    = rs2[XLEN-1];
          dz_d    = (rs2 == '0);
          rem_d   = '0;
          quo_d   = rs1_abs;
          dvs_d   = rs2_abs;
          cnt_d   = CNT_W'(DIV_STEPS - 1);
          state_d = CALC;
`ifdef DIV_SPECIAL_FASTPATH_EN
          // Preload the pre-fixup values the full iteration would reach.
          if (rs2 == '0) begin
            quo_d   = '1;
            rem_d   = rs1_abs;
            state_d = FIN;
          end else if (ovf_in) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            state_d = FIN;
          end
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            state_d = FIN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!flush) begin
          done_d    = 1'b1;
          result_d  = want_rem(op_q) ? rem_fix : quo_fix;
          tag_out_d = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_q      <= DIV;
      tag_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign tag_out = tag_out_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// tb/tb_seq_div_unit.sv - self-checking bench for seq_div_unit
module tb_seq_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  tag_in;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV_SPECIAL_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_div_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .tag_in  (tag_in),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  // Architectural RV32M result computed with plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa_i;
    int sb_i;
    bit ovf;
    sa_i = a;
    sb_i = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00:   ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa_i / sb_i);
      2'b01:   ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'(sa_i % sb_i);
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    return (FAST && special) ? 1 : 33;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Issues one op at the next falling edge, scrambles operands after
  // acceptance, then waits (bounded) for done and checks everything.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t);
    int lat;
    bit got;
    logic [31:0] res;
    logic [4:0]  tg;
    @(negedge clk);
    check({name, "/ready"}, 32'(ready), 32'd1);
    start  = 1'b1;
    op     = o;
    rs1    = a;
    rs2    = b;
    tag_in = t;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    rs1    = $urandom;
    rs2    = $urandom;
    tag_in = 5'($urandom);
    op     = 2'($urandom);
    got = 1'b0;
    lat = 0;
    res = '0;
    tg  = '0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = i;
        res = result;
        tg  = tag_out;
      end
    end
    check({name, "/done_seen"}, 32'(got), 32'd1);
    check({name, "/latency"}, 32'(lat), 32'(exp_lat(o, a, b)));
    check({name, "/result"}, res, ref_div(o, a, b));
    check({name, "/tag"}, 32'(tg), 32'(t));
  endtask

  initial begin
    int nd;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    rs1 = '0; rs2 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset/ready", 32'(ready), 32'd1);
    check("reset/done", 32'(done), 32'd0);
    check("reset/result", result, 32'd0);
    check("reset/tag", 32'(tag_out), 32'd0);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd4);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7);
    run_op("div_by0", 2'b00, 32'h1234_5678, 32'd0, 5'd8);
    run_op("rem_by0", 2'b10, 32'h1234_5678, 32'd0, 5'd9);
    run_op("divu_by0", 2'b01, 32'h8765_4321, 32'd0, 5'd10);
    run_op("remu_by0", 2'b11, 32'h8765_4321, 32'd0, 5'd11);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run_op("rem_neg_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 5'd14);

    // Back-to-back: each run_op starts in the done cycle of the previous one.
    run_op("b2b_first", 2'b01, 32'd9, 32'd3, 5'd15);
    run_op("b2b_second", 2'b01, 32'd1000, 32'd10, 5'd16);

    // Result and tag hold after the done cycle.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("hold/done", 32'(done), 32'd0);
    check("hold/result", result, 32'd100);
    check("hold/tag", 32'(tag_out), 32'd16);

    // Reset in the middle of an iteration.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1 = 32'd77; rs2 = 32'd5; tag_in = 5'd21;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst/ready", 32'(ready), 32'd1);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/result", result, 32'd0);
    check("midrst/tag", 32'(tag_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("midrst/no_done", 32'(nd), 32'd0);

    // Flush partway through DIVU 50/5.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd5; tag_in = 5'd22;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush/ready", 32'(ready), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("flush/no_done", 32'(nd), 32'd0);
    check("flush/result_held", result, 32'd0);

    // start together with flush in IDLE is dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd60; rs2 = 32'd6; tag_in = 5'd23;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start/ready", 32'(ready), 32'd1);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("flush_start/no_done", 32'(nd), 32'd0);

    run_op("after_flush", 2'b01, 32'd8, 32'd2, 5'd24);

    // Randomized ops, with corner operands mixed in.
    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rand%0d", k), ro, ra, rb, 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
